// File: rtl/ntt_polymul_seq.sv
// ntt_polymul_seq: sequential cyclic polynomial multiplier mod (x^N - 1, q) via naive NTT
// Ports:
//    clk, rst_n        clock (rising edge), asynchronous active-low reset
//    start_i           job request, accepted only while idle
//    data_a_i/data_b_i operands, coefficient i at bits [i*W +: W]
//    mod_i             modulus q
//    omega_i           primitive N-th root of unity mod q
//    inv_omega_i       omega^-1 mod q
//    inv_n_i           N^-1 mod q
//    busy_o            high from the accepting edge until done
//    done_o            one-cycle pulse, data_out_o valid
//    err_o             raised with done when q < 2, cleared on next accept
//    data_out_o        product coefficients, same packing as the operands
module ntt_polymul_seq #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [N*W-1:0] data_a_i,
   input  logic [N*W-1:0] data_b_i,
   input  logic [W-1:0]   mod_i,
   input  logic [W-1:0]   omega_i,
   input  logic [W-1:0]   inv_omega_i,
   input  logic [W-1:0]   inv_n_i,
   output logic           busy_o,
   output logic           done_o,
   output logic           err_o,
   output logic [N*W-1:0] data_out_o
);
   localparam int LG = $clog2(N);
   localparam logic [LG-1:0] LAST = LG'(N - 1);
   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] TWO = W'(2);
   typedef enum logic [2:0] {S_IDLE, S_FWD, S_PMUL, S_INV, S_SCALE, S_DONE} state_t;
   state_t          state_q;
   logic            busy_q, done_q, err_q;
   logic [N*W-1:0]  data_out_q;
   logic [W-1:0]    q_q, omega_q, inv_omega_q, inv_n_q;
   logic [W-1:0]    xa_q [N];
   logic [W-1:0]    xb_q [N];
   logic [W-1:0]    ca_q [N];
   logic [W-1:0]    cb_q [N];
   logic [W-1:0]    acc_a_q, acc_b_q, t_q, wk_q;
   logic [2*LG-1:0] ctr_q;
   logic [LG-1:0]   inner, outer;
   logic [W-1:0]    op_x, op_y, prod_a_d, prod_b_d, acc_a_d, acc_b_d, t_d, wk_d;
   function automatic logic [W-1:0] mmul(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] q);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      return W'(p % {{W{1'b0}}, q});
   endfunction
   function automatic logic [W-1:0] madd(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] q);
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s >= {1'b0, q} ? W'(s - {1'b0, q}) : W'(s);
   endfunction
   // One shared multiplier lane serves FWD/INV accumulation, PMUL and SCALE; lane b only runs in FWD.
   always_comb begin
      inner    = ctr_q[LG-1:0];
      outer    = ctr_q[2*LG-1:LG];
      op_x     = state_q == S_FWD ? xa_q[inner] : state_q == S_SCALE ? cb_q[inner] : ca_q[inner];
      op_y     = state_q == S_PMUL ? cb_q[inner] : state_q == S_SCALE ? inv_n_q : t_q;
      prod_a_d = mmul(op_x, op_y, q_q);
      prod_b_d = mmul(xb_q[inner], t_q, q_q);
      acc_a_d  = madd(acc_a_q, prod_a_d, q_q);
      acc_b_d  = madd(acc_b_q, prod_b_d, q_q);
      t_d      = mmul(t_q, wk_q, q_q);
      wk_d     = mmul(wk_q, state_q == S_FWD ? omega_q : inv_omega_q, q_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         data_out_q  <= '0;
         q_q         <= '0;
         omega_q     <= '0;
         inv_omega_q <= '0;
         inv_n_q     <= '0;
         acc_a_q     <= '0;
         acc_b_q     <= '0;
         t_q         <= '0;
         wk_q        <= '0;
         ctr_q       <= '0;
         for (int i = 0; i < N; i++) begin
            xa_q[i] <= '0;
            xb_q[i] <= '0;
            ca_q[i] <= '0;
            cb_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start_i) begin
               busy_q      <= 1'b1;
               err_q       <= 1'b0;
               q_q         <= mod_i;
               omega_q     <= omega_i;
               inv_omega_q <= inv_omega_i;
               inv_n_q     <= inv_n_i;
               acc_a_q     <= '0;
               acc_b_q     <= '0;
               t_q         <= ONE;
               wk_q        <= ONE;
               ctr_q       <= '0;
               // q < 2 would make the reduction meaningless, so skip straight to DONE
               state_q     <= mod_i < TWO ? S_DONE : S_FWD;
               for (int i = 0; i < N; i++) begin
                  xa_q[i] <= mod_i < TWO ? '0 : data_a_i[i*W +: W] % mod_i;
                  xb_q[i] <= mod_i < TWO ? '0 : data_b_i[i*W +: W] % mod_i;
               end
            end
            // ctr = {outer, inner}: twiddle t walks root^(outer*inner), wk holds root^outer
            S_FWD, S_INV: begin
               ctr_q   <= ctr_q + 1'b1;
               acc_a_q <= acc_a_d;
               acc_b_q <= acc_b_d;
               t_q     <= t_d;
               if (inner == LAST) begin
                  if (state_q == S_FWD) begin
                     ca_q[outer] <= acc_a_d;
                     cb_q[outer] <= acc_b_d;
                  end else begin
                     cb_q[outer] <= acc_a_d;
                  end
                  acc_a_q <= '0;
                  acc_b_q <= '0;
                  t_q     <= ONE;
                  wk_q    <= wk_d;
               end
               if (&ctr_q) begin
                  state_q <= state_q == S_FWD ? S_PMUL : S_SCALE;
                  wk_q    <= ONE;
               end
            end
            S_PMUL, S_SCALE: begin
               ctr_q <= ctr_q + 1'b1;
               if (state_q == S_PMUL) ca_q[inner] <= prod_a_d;
               else cb_q[inner] <= prod_a_d;
               if (inner == LAST) begin
                  ctr_q   <= '0;
                  state_q <= state_q == S_PMUL ? S_INV : S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               err_q   <= q_q < TWO;
               state_q <= S_IDLE;
               for (int i = 0; i < N; i++) data_out_q[i*W +: W] <= q_q < TWO ? '0 : cb_q[i];
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign data_out_o = data_out_q;
endmodule
